// File: rtl/dm_arbiter_if.sv
// Requester and data-memory signals of the two-port data-memory arbiter.
//
// Handshake: req[p] is the request ("valid") of port p. Its attributes (we,
// adr, wdata, wid) stay stable from the cycle req is raised through the
// cycle ack[p] is high. ack[p] is the one-cycle "done" pulse for that
// access, with err[p] and rdata valid alongside it. A port holding req
// high through its ack cycle asks for a further access, which is served
// starting in the next cycle.
interface dm_arbiter_if;
    logic [1:0]  req;
    logic [1:0]  lock;
    logic [1:0]  we;
    logic [31:0] adr0;
    logic [31:0] adr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic [2:0]  wid0;
    logic [2:0]  wid1;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [31:0] rdata;
    logic        cpu_stall;
    logic [31:0] mem_adr;
    logic [31:0] mem_write;
    logic        memw_enable;
    logic [2:0]  width;
    logic [31:0] mem_read;
    // Internal state made visible for observation.
    logic [0:0]  dbg_st;
    logic        dbg_owner;
    logic        dbg_last;
    logic [7:0]  dbg_bcnt;

    modport slave (
        input  req, lock, we, adr0, adr1, wdata0, wdata1, wid0, wid1, mem_read,
        output ack, err, rdata, cpu_stall, mem_adr, mem_write, memw_enable, width,
        output dbg_st, dbg_owner, dbg_last, dbg_bcnt
    );

    modport master (
        output req, lock, we, adr0, adr1, wdata0, wdata1, wid0, wid1, mem_read,
        input  ack, err, rdata, cpu_stall, mem_adr, mem_write, memw_enable, width,
        input  dbg_st, dbg_owner, dbg_last, dbg_bcnt
    );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory.
// Port 0 is the CPU MEM stage, port 1 the debug/DMA loader. One access per
// cycle; a locked owner may keep the memory for up to MAX_BURST accesses
// in a row while the other port waits.
module dm_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       reset,
    dm_arbiter_if.slave bus
);

    localparam int BCNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(MAX_BURST - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACC  = 1'b1;

    logic [0:0]        st_q, st_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;

    logic              in_acc;
    logic [31:0]       sel_adr;
    logic [31:0]       sel_wdata;
    logic [2:0]        sel_wid;
    logic              sel_we;
    logic              misalign;
    logic [1:0]        ack_c;
    logic [1:0]        err_c;
    logic [1:0]        pick_idle;
    logic [1:0]        pick_acc;
    logic              cont;
    logic              other_req;

    // Returns {found, port}: a sole requester wins, a tie goes to ~last_port.
    function automatic logic [1:0] pick(input logic [1:0] r, input logic last_port);
        logic [1:0] res;
        res = 2'b00;
        case (r)
            2'b01:   res = 2'b10;
            2'b10:   res = 2'b11;
            2'b11:   res = {1'b1, ~last_port};
            default: res = 2'b00;
        endcase
        return res;
    endfunction

    // Select the owner's access attributes and flag misaligned accesses.
    always_comb begin
        in_acc    = (st_q == ST_ACC);
        sel_adr   = owner_q ? bus.adr1   : bus.adr0;
        sel_wdata = owner_q ? bus.wdata1 : bus.wdata0;
        sel_wid   = owner_q ? bus.wid1   : bus.wid0;
        sel_we    = bus.we[owner_q];
        // Word needs a 4-byte boundary; any other width is handled as half.
        misalign  = (sel_wid == 3'd0) ? (sel_adr[1:0] != 2'b00) : sel_adr[0];
    end

    // Completion pulse and error flag to the current owner.
    always_comb begin
        ack_c = 2'b00;
        err_c = 2'b00;
        if (in_acc) begin
            ack_c[owner_q] = 1'b1;
            err_c[owner_q] = misalign;
        end
    end

    assign bus.ack         = ack_c;
    assign bus.err         = err_c;
    assign bus.rdata       = in_acc ? bus.mem_read : 32'd0;
    assign bus.mem_adr     = in_acc ? sel_adr : 32'd0;
    assign bus.mem_write   = in_acc ? sel_wdata : 32'd0;
    assign bus.width       = in_acc ? sel_wid : 3'd0;
    assign bus.memw_enable = in_acc & sel_we & ~misalign;
    // Stall stays low while reset is held so every output is quiet in reset.
    assign bus.cpu_stall   = reset & bus.req[0] & ~ack_c[0];

    assign bus.dbg_st    = st_q;
    assign bus.dbg_owner = owner_q;
    assign bus.dbg_last  = last_q;
    assign bus.dbg_bcnt  = 8'(bcnt_q);

    // Next-state: grant from idle, extend a locked burst, or rotate owner.
    always_comb begin
        st_d      = st_q;
        owner_d   = owner_q;
        last_d    = last_q;
        bcnt_d    = bcnt_q;
        pick_idle = pick(bus.req, last_q);
        // Re-pick after the current owner is recorded as served last.
        pick_acc  = pick(bus.req, owner_q);
        cont      = bus.lock[owner_q] & bus.req[owner_q];
        other_req = bus.req[~owner_q];
        case (st_q)
            ST_IDLE: begin
                if (pick_idle[1]) begin
                    st_d    = ST_ACC;
                    owner_d = pick_idle[0];
                    bcnt_d  = '0;
                end
            end
            ST_ACC: begin
                if (cont && (bcnt_q < BCNT_LAST)) begin
                    bcnt_d = bcnt_q + BCNT_W'(1);
                end else if (cont && !other_req) begin
                    // Burst budget spent but nobody is waiting: keep going.
                    bcnt_d = '0;
                end else begin
                    last_d = owner_q;
                    bcnt_d = '0;
                    if (pick_acc[1]) begin
                        owner_d = pick_acc[0];
                    end else begin
                        st_d = ST_IDLE;
                    end
                end
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    // State registers; last resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q    <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            bcnt_q  <= '0;
        end else begin
            st_q    <= st_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: a cycle table from reset, then burst and
// asynchronous-reset sequences. The bench also models the data memory.
module tb_dm_arbiter;

    logic clk;
    logic reset;
    logic [31:0] mem [0:63];

    int n_total;
    int n_pass;

    dm_arbiter_if bus_if ();

    dm_arbiter #(.MAX_BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [1:0]  we;
        logic [31:0] adr0;
        logic [31:0] adr1;
        logic [2:0]  wid0;
        logic [1:0]  e_ack;
        logic [1:0]  e_err;
        logic        e_memw;
        logic [31:0] e_adr;
        logic [2:0]  e_width;
        logic        chk_rd;
        logic [31:0] e_rd;
        logic        e_stall;
        logic        e_st;
    } vec_t;

    vec_t vecs [19];
    logic [9:0] exp_q [$];

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write on rising edge.
    assign bus_if.mem_read = mem[bus_if.mem_adr[7:2]];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
        forever begin
            @(posedge clk);
            if (bus_if.memw_enable) mem[bus_if.mem_adr[7:2]] <= bus_if.mem_write;
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic rst, input logic [1:0] req, input logic [1:0] we,
                                input logic [31:0] a0, input logic [31:0] a1, input logic [2:0] w0,
                                input logic [1:0] ack, input logic [1:0] err, input logic memw,
                                input logic [31:0] adr, input logic [2:0] wdt, input logic crd,
                                input logic [31:0] rd, input logic stall, input logic st);
        vec_t v;
        v.rst = rst; v.req = req; v.we = we; v.adr0 = a0; v.adr1 = a1; v.wid0 = w0;
        v.e_ack = ack; v.e_err = err; v.e_memw = memw; v.e_adr = adr; v.e_width = wdt;
        v.chk_rd = crd; v.e_rd = rd; v.e_stall = stall; v.e_st = st;
        return v;
    endfunction

    task automatic idle_inputs();
        bus_if.req    = 2'b00;
        bus_if.lock   = 2'b00;
        bus_if.we     = 2'b00;
        bus_if.adr0   = 32'h10;
        bus_if.adr1   = 32'h20;
        bus_if.wdata0 = 32'h1111_1111;
        bus_if.wdata1 = 32'hDEAD_BEEF;
        bus_if.wid0   = 3'd0;
        bus_if.wid1   = 3'd0;
    endtask

    // Holds reset over two edges, releases it 1 ns after a rising edge.
    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic drive_vec(input vec_t v);
        bus_if.req    = v.req;
        bus_if.lock   = 2'b00;
        bus_if.we     = v.we;
        bus_if.adr0   = v.adr0;
        bus_if.adr1   = v.adr1;
        bus_if.wdata0 = 32'h1111_1111;
        bus_if.wdata1 = 32'hDEAD_BEEF;
        bus_if.wid0   = v.wid0;
        bus_if.wid1   = 3'd0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;

        //            rst req  we    adr0   adr1   w0  | ack  err  mw  adr    wdt crd rdata          stl st
        vecs[0]  = mk(0, 2'b01, 2'b00, 32'h10, 32'h20, 0, 2'b00, 2'b00, 0, 32'h00, 0, 1, 32'h0,         1, 0);
        vecs[1]  = mk(0, 2'b00, 2'b00, 32'h10, 32'h20, 0, 2'b01, 2'b00, 0, 32'h10, 0, 1, 32'hA000_0004, 0, 1);
        vecs[2]  = mk(0, 2'b00, 2'b00, 32'h10, 32'h20, 0, 2'b00, 2'b00, 0, 32'h00, 0, 1, 32'h0,         0, 0);
        vecs[3]  = mk(1, 2'b11, 2'b10, 32'h10, 32'h20, 0, 2'b00, 2'b00, 0, 32'h00, 0, 1, 32'h0,         1, 0);
        vecs[4]  = mk(0, 2'b11, 2'b10, 32'h10, 32'h20, 0, 2'b01, 2'b00, 0, 32'h10, 0, 1, 32'hA000_0004, 0, 1);
        vecs[5]  = mk(0, 2'b11, 2'b10, 32'h10, 32'h20, 0, 2'b10, 2'b00, 1, 32'h20, 0, 1, 32'hA000_0008, 1, 1);
        vecs[6]  = mk(0, 2'b11, 2'b10, 32'h10, 32'h20, 0, 2'b01, 2'b00, 0, 32'h10, 0, 1, 32'hA000_0004, 0, 1);
        vecs[7]  = mk(0, 2'b11, 2'b10, 32'h10, 32'h20, 0, 2'b10, 2'b00, 1, 32'h20, 0, 1, 32'hDEAD_BEEF, 1, 1);
        vecs[8]  = mk(0, 2'b11, 2'b10, 32'h10, 32'h20, 0, 2'b01, 2'b00, 0, 32'h10, 0, 1, 32'hA000_0004, 0, 1);
        vecs[9]  = mk(0, 2'b00, 2'b10, 32'h10, 32'h20, 0, 2'b10, 2'b00, 1, 32'h20, 0, 1, 32'hDEAD_BEEF, 0, 1);
        vecs[10] = mk(0, 2'b00, 2'b10, 32'h10, 32'h20, 0, 2'b00, 2'b00, 0, 32'h00, 0, 1, 32'h0,         0, 0);
        vecs[11] = mk(0, 2'b01, 2'b01, 32'h06, 32'h20, 0, 2'b00, 2'b00, 0, 32'h00, 0, 1, 32'h0,         1, 0);
        vecs[12] = mk(0, 2'b00, 2'b01, 32'h06, 32'h20, 0, 2'b01, 2'b01, 0, 32'h06, 0, 0, 32'h0,         0, 1);
        vecs[13] = mk(0, 2'b01, 2'b01, 32'h06, 32'h20, 1, 2'b00, 2'b00, 0, 32'h00, 0, 1, 32'h0,         1, 0);
        vecs[14] = mk(0, 2'b00, 2'b01, 32'h06, 32'h20, 1, 2'b01, 2'b00, 1, 32'h06, 1, 1, 32'hA000_0001, 0, 1);
        vecs[15] = mk(0, 2'b00, 2'b01, 32'h06, 32'h20, 1, 2'b00, 2'b00, 0, 32'h00, 0, 1, 32'h0,         0, 0);
        vecs[16] = mk(0, 2'b01, 2'b00, 32'h07, 32'h20, 5, 2'b00, 2'b00, 0, 32'h00, 0, 1, 32'h0,         1, 0);
        vecs[17] = mk(0, 2'b00, 2'b00, 32'h07, 32'h20, 5, 2'b01, 2'b01, 0, 32'h07, 5, 0, 32'h0,         0, 1);
        vecs[18] = mk(0, 2'b00, 2'b00, 32'h07, 32'h20, 5, 2'b00, 2'b00, 0, 32'h00, 0, 1, 32'h0,         0, 0);

        // Reset state, with port 0 requesting to see stall held low.
        reset = 1'b0;
        idle_inputs();
        bus_if.req = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        chk("rst ack",   32'(bus_if.ack),         32'd0);
        chk("rst memw",  32'(bus_if.memw_enable), 32'd0);
        chk("rst adr",   bus_if.mem_adr,          32'd0);
        chk("rst stall", 32'(bus_if.cpu_stall),   32'd0);
        chk("rst st",    32'(bus_if.dbg_st),      32'd0);
        chk("rst owner", 32'(bus_if.dbg_owner),   32'd0);
        chk("rst last",  32'(bus_if.dbg_last),    32'd1);
        chk("rst bcnt",  32'(bus_if.dbg_bcnt),    32'd0);
        reset = 1'b1;

        // Table: inputs applied just after a rising edge, outputs checked mid-cycle.
        for (int i = 0; i < 19; i++) begin
            if (vecs[i].rst) do_reset();
            drive_vec(vecs[i]);
            @(negedge clk);
            chk($sformatf("v%0d ack", i),   32'(bus_if.ack),         32'(vecs[i].e_ack));
            chk($sformatf("v%0d err", i),   32'(bus_if.err),         32'(vecs[i].e_err));
            chk($sformatf("v%0d memw", i),  32'(bus_if.memw_enable), 32'(vecs[i].e_memw));
            chk($sformatf("v%0d adr", i),   bus_if.mem_adr,          vecs[i].e_adr);
            chk($sformatf("v%0d width", i), 32'(bus_if.width),       32'(vecs[i].e_width));
            chk($sformatf("v%0d stall", i), 32'(bus_if.cpu_stall),   32'(vecs[i].e_stall));
            chk($sformatf("v%0d st", i),    32'(bus_if.dbg_st),      32'(vecs[i].e_st));
            if (vecs[i].chk_rd) chk($sformatf("v%0d rdata", i), bus_if.rdata, vecs[i].e_rd);
            @(posedge clk);
            #1;
        end
        chk("mem[8] port1 write",  mem[8], 32'hDEAD_BEEF);
        chk("mem[1] half write",   mem[1], 32'h1111_1111);

        // Burst: port 1 locked alone, then port 0 joins.
        do_reset();
        bus_if.req    = 2'b10;
        bus_if.lock   = 2'b10;
        bus_if.we     = 2'b10;
        bus_if.adr1   = 32'h24;
        bus_if.wdata1 = 32'hC0DE_0000;
        @(negedge clk);
        chk("burst idle ack", 32'(bus_if.ack), 32'd0);
        @(posedge clk);
        #1;
        exp_q.push_back({2'b10, 8'd0});
        exp_q.push_back({2'b10, 8'd1});
        exp_q.push_back({2'b10, 8'd2});
        exp_q.push_back({2'b10, 8'd3});
        exp_q.push_back({2'b10, 8'd0});
        exp_q.push_back({2'b10, 8'd1});
        exp_q.push_back({2'b10, 8'd2});
        exp_q.push_back({2'b10, 8'd3});
        exp_q.push_back({2'b01, 8'd0});
        exp_q.push_back({2'b10, 8'd0});
        for (int c = 1; c <= 10; c++) begin
            logic [9:0] e;
            bus_if.req = (c >= 7) ? 2'b11 : 2'b10;
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("burst c%0d ack", c),  32'(bus_if.ack),      32'(e[9:8]));
            chk($sformatf("burst c%0d bcnt", c), 32'(bus_if.dbg_bcnt), 32'(e[7:0]));
            @(posedge clk);
            #1;
        end
        bus_if.req  = 2'b00;
        bus_if.lock = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("burst mem[9]", mem[9], 32'hC0DE_0000);

        // Asynchronous reset in the middle of a locked port 1 write burst.
        do_reset();
        bus_if.req    = 2'b10;
        bus_if.lock   = 2'b10;
        bus_if.we     = 2'b10;
        bus_if.adr1   = 32'h30;
        bus_if.wdata1 = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        bus_if.req = 2'b11;
        @(negedge clk);
        chk("rburst first ack",  32'(bus_if.ack),         32'b10);
        chk("rburst first memw", 32'(bus_if.memw_enable), 32'd1);
        @(posedge clk);
        #1;
        bus_if.adr1   = 32'h34;
        bus_if.wdata1 = 32'h7777_8888;
        #2;
        chk("rburst pre ack",   32'(bus_if.ack),       32'b10);
        chk("rburst pre stall", 32'(bus_if.cpu_stall), 32'd1);
        reset = 1'b0;
        #1;
        chk("rburst rst ack",   32'(bus_if.ack),         32'd0);
        chk("rburst rst memw",  32'(bus_if.memw_enable), 32'd0);
        chk("rburst rst stall", 32'(bus_if.cpu_stall),   32'd0);
        chk("rburst rst st",    32'(bus_if.dbg_st),      32'd0);
        @(posedge clk);
        #1;
        chk("rburst mem[12]", mem[12], 32'h5555_AAAA);
        chk("rburst mem[13]", mem[13], 32'hA000_000D);
        bus_if.lock = 2'b00;
        bus_if.we   = 2'b00;
        reset = 1'b1;
        @(negedge clk);
        chk("rburst rel ack",   32'(bus_if.ack),       32'd0);
        chk("rburst rel stall", 32'(bus_if.cpu_stall), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rburst first grant", 32'(bus_if.ack), 32'b01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
